bcd_serial_add_ctrl: RTL and testbench
======================================

Name: bcd_serial_add_ctrl

Overview:
Sequencing controller for a two-digit (one byte) BCD adder datapath. It accepts two NDIG-digit packed-BCD operands over a valid/ready handshake. It then adds them one byte (two digits) per clock, least-significant byte first, chaining the decimal carry between bytes. The full sum, carry-out and an invalid-digit flag are returned over a second valid/ready handshake. It is used wherever wide decimal operands, such as counters or display values, must share a single byte-wide BCD adder.

Parameters:
NDIG, 8, number of BCD digits per operand; must be even and >= 2 (elaboration error otherwise)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands present
in_ready  output  1  controller can accept operands
in_a  input  4*NDIG  operand A, digit i in bits [4i+3:4i], digit 0 least significant
in_b  input  4*NDIG  operand B, same packing
in_cin  input  1  decimal carry-in to digit 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  4*NDIG  packed-BCD sum, same packing as inputs
out_cout  output  1  decimal carry-out of digit NDIG-1
out_err  output  1  at least one operand digit was > 9

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; all registers cleared. out_valid=0, out_sum=0, out_cout=0, out_err=0. in_ready=1 from the first cycle after reset. Reset overrides everything, including mid-operation; an abandoned operation produces no result.
- FSM states: IDLE, ADD, DONE.
- in_ready=1 only in IDLE. out_valid=1 only in DONE. Both are decoded from the state register, with no combinational path from inputs.
- IDLE: on in_valid&in_ready, capture in_a, in_b and in_cin into operand shift registers and the carry register. Clear the byte counter and err. Go to ADD.
- ADD, one byte per cycle, NDIG/2 cycles:
  - Take the low byte of each operand register. Compute two digit additions using the carry register as the digit-0 carry-in.
  - Shift the operands right 8 bits. Shift the result byte into the top of the sum register.
  - Update the carry register. Increment the counter.
  - On the cycle processing byte NDIG/2-1, go to DONE.
- Digit rule: t = a_d + b_d + c_in, 5-bit. If t > 9: digit = (t+6) mod 16, c_out = 1. Otherwise: digit = t, c_out = 0.
- err sets (sticky for the operation) if any operand digit processed is > 9. The sum is still computed by the digit rule.
- DONE: out_sum, out_cout and out_err are stable and held while out_ready=0. On out_ready=1, go to IDLE.
- No same-cycle turnaround: in_ready rises the cycle after the result handshake.
- out_sum, out_cout and out_err keep their last value in IDLE/ADD and are only meaningful when out_valid=1.
- Latency: out_valid rises exactly NDIG/2 clock edges after the accepting edge. Throughput is one operation per NDIG/2+2 cycles.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

Decomposition:
- Shared package: state enum (IDLE/ADD/DONE), BCD_MAX=9, BCD_CORR=6, and the helper constant for byte-counter width clog2(NDIG/2) (min 1).
- Sub-module bcd_digit_add: a_d[3:0], b_d[3:0], cin → s_d[3:0], cout, err_d. It is combinational and implements the digit rule; two instances are chained per cycle.
- The controller holds the FSM, shift registers, counter and carry/err registers.

Test Plan (NDIG=8):
1. a=12345678, b=87654321, cin=0 → sum=99999999, cout=0, err=0; out_valid exactly 4 edges after acceptance.
2. a=99999999, b=00000001, cin=0 → sum=00000000, cout=1, err=0 (carry ripples across all 4 bytes).
3. a=00000009, b=00000001, cin=1 → sum=00000011, cout=0; and a=00000050, b=00000050 → sum=00000100.
4. a=0000000A, b=00000000 → err=1, sum digit0 = (10+6) mod 16 = 0 with a digit-1 carry giving sum=00000010; a subsequent valid op returns err=0.
5. Hold out_ready=0 for 3 cycles in DONE while pulsing in_valid → outputs unchanged, in_ready=0, the new operand is not accepted. Release → IDLE, in_ready=1 next cycle.
6. Assert rst for 1 cycle during the 2nd ADD cycle → out_valid never rises for that op; in_ready=1 after reset; the next op (test 1 values) is correct.

Source files
------------

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// bcd_serial_add_ctrl_pkg: shared types and constants for the serial BCD adder controller.
package bcd_serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    function automatic int cnt_w(input int ndig);
        return (ndig / 2 > 2) ? $clog2(ndig / 2) : 1;
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// bcd_digit_add: one decimal digit of a + b + cin with correction, carry-out and invalid-digit flag.
module bcd_digit_add
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [3:0] a_d_i,
    input  logic [3:0] b_d_i,
    input  logic       cin_i,
    output logic [3:0] s_d_o,
    output logic       cout_o,
    output logic       err_d_o
);

    logic [4:0] t;
    logic [4:0] t_corr;

    assign t       = {1'b0, a_d_i} + {1'b0, b_d_i} + {4'b0, cin_i};
    assign t_corr  = t + 5'(BCD_CORR);
    assign cout_o  = t > 5'(BCD_MAX);
    assign s_d_o   = cout_o ? t_corr[3:0] : t[3:0];
    assign err_d_o = (a_d_i > 4'(BCD_MAX)) || (b_d_i > 4'(BCD_MAX));

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: adds two NDIG-digit packed-BCD operands one byte per clock through a shared
// two-digit adder, least-significant byte first, with valid/ready on both sides.
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int NDIG = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_a,
    input  logic [4*NDIG-1:0] in_b,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_sum,
    output logic              out_cout,
    output logic              out_err
);

    localparam int W  = 4 * NDIG;
    localparam int CW = cnt_w(NDIG);

    if ((NDIG < 2) || (NDIG % 2 != 0)) begin : g_bad_ndig
        $error("bcd_serial_add_ctrl: NDIG must be even and >= 2");
    end

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            carry_q, carry_d, err_q, err_d;
    logic            rcout_q, rcout_d, rerr_q, rerr_d;
    logic [7:0]      byte_sum;
    logic            c0, c1, e0, e1, err_nx, last, accept;
    logic [W+7:0]    sum_cat;
    logic [W-1:0]    sum_nx;

    bcd_digit_add u_lo (
        .a_d_i   (a_q[3:0]),
        .b_d_i   (b_q[3:0]),
        .cin_i   (carry_q),
        .s_d_o   (byte_sum[3:0]),
        .cout_o  (c0),
        .err_d_o (e0)
    );

    bcd_digit_add u_hi (
        .a_d_i   (a_q[7:4]),
        .b_d_i   (b_q[7:4]),
        .cin_i   (c0),
        .s_d_o   (byte_sum[7:4]),
        .cout_o  (c1),
        .err_d_o (e1)
    );

    assign accept  = (state_q == IDLE) && in_valid;
    assign last    = cnt_q == CW'(NDIG / 2 - 1);
    assign err_nx  = err_q | e0 | e1;
    // Concatenate then shift so NDIG=2 needs no special-cased slice.
    assign sum_cat = {byte_sum, sum_q} >> 8;
    assign sum_nx  = sum_cat[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            rcout_q <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            rcout_q <= rcout_d;
            rerr_q  <= rerr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = in_valid ? ADD : IDLE;
        else if (state_q == ADD)
            state_d = last ? DONE : ADD;
        else if (state_q == DONE)
            state_d = out_ready ? IDLE : DONE;
        else
            state_d = IDLE;
    end

    // Result registers are loaded only on the final byte so the outputs hold outside DONE.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        err_d   = err_q;
        rcout_d = rcout_q;
        rerr_d  = rerr_q;
        if (accept) begin
            a_d     = in_a;
            b_d     = in_b;
            carry_d = in_cin;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (state_q == ADD) begin
            a_d     = a_q >> 8;
            b_d     = b_q >> 8;
            sum_d   = sum_nx;
            carry_d = c1;
            cnt_d   = cnt_q + CW'(1);
            err_d   = err_nx;
            res_d   = last ? sum_nx : res_q;
            rcout_d = last ? c1 : rcout_q;
            rerr_d  = last ? err_nx : rerr_q;
        end
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        out_sum   = res_q;
        out_cout  = rcout_q;
        out_err   = rerr_q;
    end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: vector table plus scoreboard for the serial BCD adder controller.
module tb_bcd_serial_add_ctrl;

    localparam int NDIG = 8;
    localparam int W    = 4 * NDIG;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_err;

    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t tbl[8];
    vec_t sb[$];

    bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input int hold, input bit pulse);
        int   k;
        int   lat;
        vec_t e;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_a = v.a;
        in_b = v.b;
        in_cin = v.cin;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(NDIG / 2));
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_a = 32'h11111111;
                in_b = 32'h22222222;
                in_valid = 1'b1;
            end
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sum", out_sum, v.sum);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("sum", out_sum, e.sum);
            chk("cout", 32'(out_cout), 32'(e.cout));
            chk("err", 32'(out_err), 32'(e.err));
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        tbl[0] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
        tbl[1] = '{32'h99999999, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[2] = '{32'h00000009, 32'h00000001, 1'b1, 32'h00000011, 1'b0, 1'b0};
        tbl[3] = '{32'h00000050, 32'h00000050, 1'b0, 32'h00000100, 1'b0, 1'b0};
        tbl[4] = '{32'h0000000A, 32'h00000000, 1'b0, 32'h00000010, 1'b0, 1'b1};
        tbl[5] = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0};
        tbl[6] = '{32'h99999999, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[7] = '{32'hF0000000, 32'h00000000, 1'b0, 32'h50000000, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", out_sum, 32'h0);
        chk("rst_cout", 32'(out_cout), 32'd0);
        chk("rst_err", 32'(out_err), 32'd0);

        for (int i = 0; i < 8; i++) do_op(tbl[i], 0, 1'b0);

        do_op(tbl[3], 3, 1'b1);
        do_op(tbl[2], 0, 1'b0);

        in_a = tbl[1].a;
        in_b = tbl[1].b;
        in_cin = tbl[1].cin;
        in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(tbl[1]);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", out_sum, 32'h0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        do_op(tbl[0], 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
